// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu -- registered two-operand arithmetic/logic unit
//
// Purpose:
//   Performs one of four operations on each rising clock edge and registers
//   the outcome, giving a fixed latency of one cycle with a new operation
//   accepted every cycle.
//     opcode 00 ADD : result = a + b, carry = unsigned carry out,
//                     overflow = two's complement overflow
//     opcode 01 SUB : result = a - b, carry = borrow (a < b unsigned),
//                     overflow = two's complement overflow
//     opcode 10 MUL : product = unsigned a * b (full width),
//                     result = low half, overflow = high half nonzero
//     opcode 11 AND : result = a & b, flags cleared
//   Except for MUL, product is result zero-extended to 2*WIDTH bits.
//
// Configuration:
//   ALU_MUL_EN  when defined, opcode 10 performs the multiply. When
//               undefined no multiplier exists and opcode 10 yields all
//               outputs 0.
//
// Ports:
//   clk       in   1          clock, rising edge active
//   rst       in   1          asynchronous active-high reset
//   a         in   WIDTH      operand A
//   b         in   WIDTH      operand B
//   opcode    in   2          operation select
//   carry     out  1          registered carry/borrow flag
//   overflow  out  1          registered signed/multiply overflow flag
//   result    out  WIDTH      registered primary result
//   product   out  2*WIDTH    registered full-width result
// ---------------------------------------------------------------------------
module alu #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [1:0]           opcode,
  output logic                 carry,
  output logic                 overflow,
  output logic [WIDTH-1:0]     result,
  output logic [2*WIDTH-1:0]   product
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_AND = 2'b11;

  // One extra bit on sum/difference exposes carry-out and borrow directly.
  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       diff;

  logic                 next_carry;
  logic                 next_overflow;
  logic [WIDTH-1:0]     next_result;
  logic [2*WIDTH-1:0]   next_product;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

`ifdef ALU_MUL_EN
  // Zero-extend before multiplying so the full 2*WIDTH product is kept.
  logic [2*WIDTH-1:0]   mul_full;
  assign mul_full = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
`endif

  always_comb begin
    next_carry    = 1'b0;
    next_overflow = 1'b0;
    next_result   = '0;
    next_product  = '0;
    case (opcode)
      OP_ADD: begin
        next_result   = sum[WIDTH-1:0];
        next_carry    = sum[WIDTH];
        next_overflow = (a[WIDTH-1] == b[WIDTH-1]) &&
                        (sum[WIDTH-1] != a[WIDTH-1]);
        next_product  = {{WIDTH{1'b0}}, sum[WIDTH-1:0]};
      end
      OP_SUB: begin
        // The borrow bit of the widened difference is set exactly when a < b.
        next_result   = diff[WIDTH-1:0];
        next_carry    = diff[WIDTH];
        next_overflow = (a[WIDTH-1] != b[WIDTH-1]) &&
                        (diff[WIDTH-1] != a[WIDTH-1]);
        next_product  = {{WIDTH{1'b0}}, diff[WIDTH-1:0]};
      end
      OP_MUL: begin
`ifdef ALU_MUL_EN
        next_product  = mul_full;
        next_result   = mul_full[WIDTH-1:0];
        next_overflow = |mul_full[2*WIDTH-1:WIDTH];
`else
        next_product  = '0;
        next_result   = '0;
        next_overflow = 1'b0;
`endif
      end
      OP_AND: begin
        next_result   = a & b;
        next_product  = {{WIDTH{1'b0}}, a & b};
      end
      default: begin
        next_result   = '0;
      end
    endcase
  end

  // Output registers; reset clears them immediately, independent of clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry    <= 1'b0;
      overflow <= 1'b0;
      result   <= '0;
      product  <= '0;
    end else begin
      carry    <= next_carry;
      overflow <= next_overflow;
      result   <= next_result;
      product  <= next_product;
    end
  end

endmodule

// File: tb/tb_alu.sv
// ---------------------------------------------------------------------------
// tb_alu -- directed self-checking bench for alu (WIDTH = 8)
//
// Each vector packs {opcode, a, b, carry, overflow, result, product}.
// Inputs change on the falling edge; outputs are sampled 1 ns after the
// rising edge that captured them. MUL expectations follow ALU_MUL_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu;

  logic        clk;
  logic        rst;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [1:0]  opcode;
  logic        carry;
  logic        overflow;
  logic [7:0]  result;
  logic [15:0] product;

  int checks;
  int fails;

  alu #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .opcode   (opcode),
    .carry    (carry),
    .overflow (overflow),
    .result   (result),
    .product  (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one operation and wait until it has been captured.
  task automatic cycle(input logic [1:0] op, input logic [7:0] va, input logic [7:0] vb);
    @(negedge clk);
    opcode = op;
    a      = va;
    b      = vb;
    @(posedge clk);
    #1;
  endtask

  // Runs a vector table: {op[43:42], a[41:34], b[33:26], c, v, res, prod}.
  task automatic run_table(input string name, input logic [43:0] vec [], input int n);
    logic [25:0] obs;
    for (int i = 0; i < n; i++) begin
      cycle(vec[i][43:42], vec[i][41:34], vec[i][33:26]);
      obs = {carry, overflow, result, product};
      checks++;
      if (obs !== vec[i][25:0]) begin
        fails++;
        $display("[TB] FAIL %s[%0d] op=%b a=%h b=%h got c=%b v=%b r=%h p=%h want c=%b v=%b r=%h p=%h",
                 name, i, vec[i][43:42], vec[i][41:34], vec[i][33:26],
                 obs[25], obs[24], obs[23:16], obs[15:0],
                 vec[i][25], vec[i][24], vec[i][23:16], vec[i][15:0]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a = 8'h55; b = 8'hAA; opcode = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({carry, overflow, result, product} !== 26'h0) begin
      fails++;
      $display("[TB] FAIL reset_hold got c=%b v=%b r=%h p=%h want all 0",
               carry, overflow, result, product);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({carry, overflow, result, product} !== {1'b0, 1'b0, 8'hFF, 16'h00FF}) begin
      fails++;
      $display("[TB] FAIL reset_release got c=%b v=%b r=%h p=%h want c=0 v=0 r=ff p=00ff",
               carry, overflow, result, product);
    end
  endtask

  task automatic test_add();
    logic [43:0] v [] = new[4];
    v[0] = {2'b00, 8'h7F, 8'h01, 1'b0, 1'b1, 8'h80, 16'h0080};
    v[1] = {2'b00, 8'hFF, 8'h01, 1'b1, 1'b0, 8'h00, 16'h0000};
    v[2] = {2'b00, 8'h80, 8'h80, 1'b1, 1'b1, 8'h00, 16'h0000};
    v[3] = {2'b00, 8'h21, 8'h13, 1'b0, 1'b0, 8'h34, 16'h0034};
    run_table("add", v, 4);
  endtask

  task automatic test_sub();
    logic [43:0] v [] = new[4];
    v[0] = {2'b01, 8'h03, 8'h05, 1'b1, 1'b0, 8'hFE, 16'h00FE};
    v[1] = {2'b01, 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 16'h007F};
    v[2] = {2'b01, 8'h5A, 8'h5A, 1'b0, 1'b0, 8'h00, 16'h0000};
    v[3] = {2'b01, 8'h7F, 8'hFF, 1'b1, 1'b1, 8'h80, 16'h0080};
    run_table("sub", v, 4);
  endtask

  task automatic test_mul();
    logic [43:0] v [] = new[3];
`ifdef ALU_MUL_EN
    v[0] = {2'b10, 8'h10, 8'h10, 1'b0, 1'b1, 8'h00, 16'h0100};
    v[1] = {2'b10, 8'h0C, 8'h0A, 1'b0, 1'b0, 8'h78, 16'h0078};
    v[2] = {2'b10, 8'hFF, 8'hFF, 1'b0, 1'b1, 8'h01, 16'hFE01};
`else
    v[0] = {2'b10, 8'h10, 8'h10, 1'b0, 1'b0, 8'h00, 16'h0000};
    v[1] = {2'b10, 8'h0C, 8'h0A, 1'b0, 1'b0, 8'h00, 16'h0000};
    v[2] = {2'b10, 8'hFF, 8'hFF, 1'b0, 1'b0, 8'h00, 16'h0000};
`endif
    run_table("mul", v, 3);
  endtask

  task automatic test_and();
    logic [43:0] v [] = new[2];
    v[0] = {2'b11, 8'hF0, 8'h3C, 1'b0, 1'b0, 8'h30, 16'h0030};
    v[1] = {2'b11, 8'hFF, 8'hFF, 1'b0, 1'b0, 8'hFF, 16'h00FF};
    run_table("and", v, 2);
  endtask

  task automatic test_back_to_back();
    logic [43:0] v [] = new[5];
    v[0] = {2'b00, 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 16'h0046};
    v[1] = {2'b01, 8'h10, 8'h20, 1'b1, 1'b0, 8'hF0, 16'h00F0};
    v[2] = {2'b11, 8'hAA, 8'h0F, 1'b0, 1'b0, 8'h0A, 16'h000A};
`ifdef ALU_MUL_EN
    v[3] = {2'b10, 8'h03, 8'h05, 1'b0, 1'b0, 8'h0F, 16'h000F};
`else
    v[3] = {2'b10, 8'h03, 8'h05, 1'b0, 1'b0, 8'h00, 16'h0000};
`endif
    v[4] = {2'b00, 8'hC0, 8'hC0, 1'b1, 1'b0, 8'h80, 16'h0080};
    run_table("b2b", v, 5);
  endtask

  // Inputs changed between edges must not reach the outputs early.
  task automatic test_opcode_hold();
    cycle(2'b00, 8'h7F, 8'h01);
    #2;
    opcode = 2'b11;
    a      = 8'h0F;
    #1;
    checks++;
    if ({carry, overflow, result, product} !== {1'b0, 1'b1, 8'h80, 16'h0080}) begin
      fails++;
      $display("[TB] FAIL opcode_hold got c=%b v=%b r=%h p=%h want c=0 v=1 r=80 p=0080",
               carry, overflow, result, product);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({carry, overflow, result, product} !== {1'b0, 1'b0, 8'h01, 16'h0001}) begin
      fails++;
      $display("[TB] FAIL opcode_hold_next got c=%b v=%b r=%h p=%h want c=0 v=0 r=01 p=0001",
               carry, overflow, result, product);
    end
  endtask

  // Mid-cycle reset clears at once and discards the in-flight operation.
  task automatic test_async_reset();
    cycle(2'b00, 8'hFF, 8'h01);
    cycle(2'b01, 8'h03, 8'h05);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({carry, overflow, result, product} !== 26'h0) begin
      fails++;
      $display("[TB] FAIL async_reset got c=%b v=%b r=%h p=%h want all 0",
               carry, overflow, result, product);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({carry, overflow, result, product} !== 26'h0) begin
      fails++;
      $display("[TB] FAIL reset_edge got c=%b v=%b r=%h p=%h want all 0",
               carry, overflow, result, product);
    end
    @(negedge clk);
    rst    = 1'b0;
    opcode = 2'b11;
    a      = 8'hF0;
    b      = 8'h3C;
    @(posedge clk);
    #1;
    checks++;
    if ({carry, overflow, result, product} !== {1'b0, 1'b0, 8'h30, 16'h0030}) begin
      fails++;
      $display("[TB] FAIL reset_recover got c=%b v=%b r=%h p=%h want c=0 v=0 r=30 p=0030",
               carry, overflow, result, product);
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    rst    = 1'b1;
    a      = '0;
    b      = '0;
    opcode = '0;
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_and();
    test_back_to_back();
    test_opcode_hold();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule
